// File: rtl/ex_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_result_stage
// Purpose  : EX->WB pipeline register with PSR, registered branch decision
//            and a saturating overflow-event counter.
// Revision : 1.0
// ============================================================================
module ex_result_stage #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EX_VALID,
  input  logic             STALL,
  input  logic             FLUSH,
  input  logic [31:0]      F,
  input  logic             Z_in,
  input  logic             C_in,
  input  logic             N_in,
  input  logic             V_in,
  input  logic [4:0]       DA,
  input  logic             RW,
  input  logic             MD,
  input  logic             SCC,
  input  logic [2:0]       BC,
  output logic             WB_VALID,
  output logic [31:0]      WB_DATA,
  output logic [4:0]       WB_DA,
  output logic             WB_RW,
  output logic [3:0]       PSR,
  output logic             BR_TAKEN,
  output logic [CNT_W-1:0] OVF_CNT
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  logic             r_wb_valid;
  logic [31:0]      r_wb_data;
  logic [4:0]       r_wb_da;
  logic             r_wb_rw;
  logic [3:0]       r_psr;
  logic             r_br_taken;
  logic [CNT_W-1:0] r_ovf_cnt;

  logic [3:0]       w_flags_in;
  logic [3:0]       w_nf;
  logic             w_br_cond;
  logic [31:0]      w_result;

  assign w_flags_in = {Z_in, C_in, N_in, V_in};
  // Branch sees the flags this instruction produces when it sets them.
  assign w_nf       = SCC ? w_flags_in : r_psr;
  assign w_result   = MD ? {31'b0, N_in ^ V_in} : F;

  always_comb begin
    w_br_cond = 1'b0;
    case (BC)
      3'b000:  w_br_cond = 1'b0;
      3'b001:  w_br_cond = w_nf[3];
      3'b010:  w_br_cond = ~w_nf[3];
      3'b011:  w_br_cond = w_nf[1];
      3'b100:  w_br_cond = ~w_nf[1];
      3'b101:  w_br_cond = w_nf[2];
      3'b110:  w_br_cond = w_nf[0];
      default: w_br_cond = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wb_valid <= 1'b0;
      r_wb_data  <= '0;
      r_wb_da    <= '0;
      r_wb_rw    <= 1'b0;
      r_psr      <= '0;
      r_br_taken <= 1'b0;
      r_ovf_cnt  <= '0;
    end else if (FLUSH) begin
      r_wb_valid <= 1'b0;
      r_wb_rw    <= 1'b0;
      r_br_taken <= 1'b0;
    end else if (!STALL) begin
      r_wb_valid <= EX_VALID;
      if (EX_VALID) begin
        r_wb_data  <= w_result;
        r_wb_da    <= DA;
        r_wb_rw    <= RW & (DA != 5'd0);
        r_br_taken <= w_br_cond;
        if (SCC) begin
          r_psr <= w_flags_in;
          if (V_in && (r_ovf_cnt != C_CNT_MAX)) begin
            r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
          end
        end
      end else begin
        r_wb_rw    <= 1'b0;
        r_br_taken <= 1'b0;
      end
    end
  end

  assign WB_VALID = r_wb_valid;
  assign WB_DATA  = r_wb_data;
  assign WB_DA    = r_wb_da;
  assign WB_RW    = r_wb_rw;
  assign PSR      = r_psr;
  assign BR_TAKEN = r_br_taken;
  assign OVF_CNT  = r_ovf_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ex_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_result_stage
// Purpose  : Directed and randomized checks of ex_result_stage against a
//            behavioural model of the stage.
// Revision : 1.0
// ============================================================================
module tb_ex_result_stage;

  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, ex_valid, stall, flush;
  logic [31:0]      f;
  logic             z_in, c_in, n_in, v_in;
  logic [4:0]       da;
  logic             rw, md, scc;
  logic [2:0]       bc;
  logic             wb_valid, wb_rw, br_taken;
  logic [31:0]      wb_data;
  logic [4:0]       wb_da;
  logic [3:0]       psr;
  logic [CNT_W-1:0] ovf_cnt;

  int checks = 0;
  int errors = 0;

  // Model state
  bit        m_valid, m_rw, m_br;
  bit [31:0] m_data;
  bit [4:0]  m_da;
  bit [3:0]  m_psr;
  int        m_cnt;

  ex_result_stage #(.CNT_W(CNT_W)) dut (
    .CLK(clk), .RESET(rst), .EX_VALID(ex_valid), .STALL(stall), .FLUSH(flush),
    .F(f), .Z_in(z_in), .C_in(c_in), .N_in(n_in), .V_in(v_in),
    .DA(da), .RW(rw), .MD(md), .SCC(scc), .BC(bc),
    .WB_VALID(wb_valid), .WB_DATA(wb_data), .WB_DA(wb_da), .WB_RW(wb_rw),
    .PSR(psr), .BR_TAKEN(br_taken), .OVF_CNT(ovf_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit branch_cond(input bit [2:0] sel, input bit [3:0] fl);
    bit zf = fl[3], cf = fl[2], nf = fl[1], vf = fl[0];
    case (sel)
      3'd0: return 1'b0;
      3'd1: return zf;
      3'd2: return !zf;
      3'd3: return nf;
      3'd4: return !nf;
      3'd5: return cf;
      3'd6: return vf;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_update();
    bit [3:0] fin = {z_in, c_in, n_in, v_in};
    if (rst) begin
      m_valid = 0; m_rw = 0; m_br = 0; m_data = 0; m_da = 0; m_psr = 0; m_cnt = 0;
    end else if (flush) begin
      m_valid = 0; m_rw = 0; m_br = 0;
    end else if (!stall) begin
      m_valid = ex_valid;
      if (ex_valid) begin
        m_data = md ? 32'(n_in != v_in) : f;
        m_da   = da;
        m_rw   = rw && (da != 0);
        m_br   = branch_cond(bc, scc ? fin : m_psr);
        if (scc) m_psr = fin;
        if (scc && v_in && m_cnt < CNT_MAX) m_cnt++;
      end else begin
        m_rw = 0; m_br = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_in(input bit ev, input bit [31:0] fv, input bit [3:0] fl,
                        input bit [4:0] dav, input bit rwv, input bit mdv,
                        input bit sccv, input bit [2:0] bcv);
    ex_valid = ev; f = fv; {z_in, c_in, n_in, v_in} = fl;
    da = dav; rw = rwv; md = mdv; scc = sccv; bc = bcv;
  endtask

  task automatic test_reset();
    rst = 1; stall = 0; flush = 0;
    set_in(1, 32'hFFFF_FFFF, 4'b0011, 5'd7, 1, 0, 1, 3'd7);
    step(); step();
    checks++;
    if ({wb_valid, wb_data, wb_da, wb_rw, psr, br_taken} !== '0 || ovf_cnt !== '0) begin
      errors++;
      $display("FAIL reset_state: got valid=%0b data=%h da=%0d rw=%0b psr=%b br=%0b cnt=%0d expected all zero",
               wb_valid, wb_data, wb_da, wb_rw, psr, br_taken, ovf_cnt);
    end
    rst = 0;
    step();
    checks++;
    if (wb_data !== 32'hFFFF_FFFF || psr !== 4'b0011 || wb_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_accept: got data=%h psr=%b valid=%0b expected FFFFFFFF 0011 1",
               wb_data, psr, wb_valid);
    end
  endtask

  task automatic test_capture();
    set_in(1, 32'h5555_5554, 4'b0000, 5'd5, 1, 0, 0, 3'd0);
    step();
    checks++;
    if (wb_data !== 32'h5555_5554 || wb_da !== 5'd5 || wb_rw !== 1'b1) begin
      errors++;
      $display("FAIL capture: got data=%h da=%0d rw=%0b expected 55555554 5 1", wb_data, wb_da, wb_rw);
    end
    da = 5'd0;
    step();
    checks++;
    if (wb_rw !== 1'b0 || wb_valid !== 1'b1 || wb_da !== 5'd0) begin
      errors++;
      $display("FAIL r0_suppress: got rw=%0b valid=%0b da=%0d expected 0 1 0", wb_rw, wb_valid, wb_da);
    end
  endtask

  task automatic test_slt();
    set_in(1, 32'hDEAD_BEEF, 4'b0010, 5'd9, 1, 1, 0, 3'd0);
    step();
    checks++;
    if (wb_data !== 32'h1) begin
      errors++;
      $display("FAIL slt_n1v0: got %h expected 00000001", wb_data);
    end
    v_in = 1;
    step();
    checks++;
    if (wb_data !== 32'h0) begin
      errors++;
      $display("FAIL slt_n1v1: got %h expected 00000000", wb_data);
    end
  endtask

  task automatic test_branch_forward();
    set_in(1, 32'h0, 4'b0000, 5'd1, 0, 0, 1, 3'd0);
    step();
    set_in(1, 32'h0, 4'b1000, 5'd1, 0, 0, 1, 3'd1);
    step();
    checks++;
    if (br_taken !== 1'b1 || psr !== 4'b1000) begin
      errors++;
      $display("FAIL branch_fwd: got br=%0b psr=%b expected 1 1000", br_taken, psr);
    end
    set_in(1, 32'h0, 4'b0000, 5'd1, 0, 0, 0, 3'd2);
    step();
    checks++;
    if (br_taken !== 1'b0 || psr !== 4'b1000) begin
      errors++;
      $display("FAIL branch_held_psr: got br=%0b psr=%b expected 0 1000", br_taken, psr);
    end
  endtask

  task automatic test_stall_flush();
    bit [31:0] d0; bit [4:0] a0; bit [3:0] p0; bit [CNT_W-1:0] c0;
    set_in(1, 32'h1234_5678, 4'b0100, 5'd3, 1, 0, 1, 3'd7);
    step();
    d0 = wb_data; a0 = wb_da; p0 = psr; c0 = ovf_cnt;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_in(1, $urandom, 4'b1111, 5'd12, 1, 0, 1, 3'd0);
      step();
      checks++;
      if (wb_valid !== 1'b1 || wb_data !== d0 || wb_da !== a0 || wb_rw !== 1'b1 ||
          psr !== p0 || br_taken !== 1'b1 || ovf_cnt !== c0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got valid=%0b data=%h da=%0d rw=%0b psr=%b br=%0b cnt=%0d expected 1 %h %0d 1 %b 1 %0d",
                 i, wb_valid, wb_data, wb_da, wb_rw, psr, br_taken, ovf_cnt, d0, a0, p0, c0);
      end
    end
    flush = 1;
    step();
    checks++;
    if (wb_valid !== 1'b0 || wb_rw !== 1'b0 || br_taken !== 1'b0 || psr !== p0 ||
        wb_data !== d0 || ovf_cnt !== c0) begin
      errors++;
      $display("FAIL flush_stall: got valid=%0b rw=%0b br=%0b psr=%b data=%h cnt=%0d expected 0 0 0 %b %h %0d",
               wb_valid, wb_rw, br_taken, psr, wb_data, ovf_cnt, p0, d0, c0);
    end
    flush = 0; stall = 0;
  endtask

  task automatic test_counter_sat();
    int exp_seq[5] = '{1, 2, 3, 3, 3};
    rst = 1;
    step();
    rst = 0;
    set_in(1, 32'h0, 4'b0001, 5'd2, 1, 0, 0, 3'd0);
    step();
    checks++;
    if (ovf_cnt !== 0) begin
      errors++;
      $display("FAIL cnt_no_scc: got %0d expected 0", ovf_cnt);
    end
    scc = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (ovf_cnt !== exp_seq[i][CNT_W-1:0]) begin
        errors++;
        $display("FAIL cnt_sat[%0d]: got %0d expected %0d", i, ovf_cnt, exp_seq[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(99) < 2);
      flush = ($urandom_range(99) < 10);
      stall = ($urandom_range(99) < 20);
      set_in($urandom_range(99) < 75, $urandom, 4'($urandom), 5'($urandom_range(3) == 0 ? 0 : $urandom),
             1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom));
      step();
      checks++;
      if (wb_valid !== m_valid || wb_data !== m_data || wb_da !== m_da || wb_rw !== m_rw ||
          psr !== m_psr || br_taken !== m_br || ovf_cnt !== m_cnt[CNT_W-1:0]) begin
        errors++;
        $display("FAIL random[%0d]: got v=%0b d=%h a=%0d rw=%0b psr=%b br=%0b cnt=%0d expected v=%0b d=%h a=%0d rw=%0b psr=%b br=%0b cnt=%0d",
                 i, wb_valid, wb_data, wb_da, wb_rw, psr, br_taken, ovf_cnt,
                 m_valid, m_data, m_da, m_rw, m_psr, m_br, m_cnt);
      end
    end
    rst = 0; flush = 0; stall = 0;
  endtask

  initial begin
    test_reset();
    test_capture();
    test_slt();
    test_branch_forward();
    test_stall_flush();
    test_counter_sat();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_result_stage.md
Name: ex_result_stage

Overview:
- Pipeline register between the function unit (F, Z/C/N/V flags) and register-file writeback.
- Captures the function-unit result and flags, and selects the writeback value: F, or the set-less-than bit N^V.
- Holds the processor status register (PSR), resolves the branch condition against the updated flags, and keeps a saturating overflow-event counter.
- Supports stall (hold) and flush (bubble insertion).

Parameters:
- CNT_W, 8, width of the overflow event counter OVF_CNT.

Ports:
- CLK  input  1  rising-edge clock
- RESET  input  1  synchronous, active-high reset
- EX_VALID  input  1  execute stage presents a valid instruction this cycle
- STALL  input  1  hold all stage registers
- FLUSH  input  1  discard the incoming instruction, insert a bubble
- F  input  32  function-unit result
- Z_in, C_in, N_in, V_in  input  1 each  function-unit flags
- DA  input  5  destination register address
- RW  input  1  register-write request
- MD  input  1  result select: 0 = F; 1 = {31'b0, N_in^V_in}
- SCC  input  1  set condition codes (update PSR)
- BC  input  3  branch condition select
- WB_VALID  output  1  writeback slot holds a valid instruction
- WB_DATA  output  32  writeback value
- WB_DA  output  5  writeback register address
- WB_RW  output  1  qualified register-write enable
- PSR  output  4  status register {Z,C,N,V}
- BR_TAKEN  output  1  registered branch decision
- OVF_CNT  output  CNT_W  saturating count of flag-setting overflows

Behaviour:
- Synchronous logic only; all state changes on the CLK rising edge. Priority is RESET > FLUSH > STALL > normal capture.
- RESET=1: every output register is cleared to 0 (WB_VALID, WB_DATA, WB_DA, WB_RW, PSR, BR_TAKEN, OVF_CNT). RESET asserted mid-stall or mid-flush still clears everything on that edge.
- Accept condition: acc = EX_VALID & ~FLUSH & ~STALL.
- FLUSH=1, regardless of STALL:
  - WB_VALID<=0, WB_RW<=0, BR_TAKEN<=0.
  - WB_DATA, WB_DA, PSR and OVF_CNT hold.
- STALL=1 and FLUSH=0: every register holds.
- Normal (STALL=0, FLUSH=0):
  - WB_VALID<=EX_VALID.
  - If EX_VALID=1:
    - WB_DATA<= MD ? {31'b0, N_in^V_in} : F.
    - WB_DA<=DA.
    - WB_RW<=RW & (DA!=0). R0 is never written.
  - If EX_VALID=0: WB_RW<=0 and BR_TAKEN<=0; WB_DATA and WB_DA hold.
- PSR update: when acc & SCC, PSR<={Z_in,C_in,N_in,V_in}; otherwise PSR holds.
- Branch evaluation, when acc:
  - Flags used: nf = SCC ? {Z_in,C_in,N_in,V_in} : PSR. An instruction can therefore branch on the flags it produces itself.
  - BC encoding: 000 never; 001 Z; 010 ~Z; 011 N; 100 ~N; 101 C; 110 V; 111 always.
  - BR_TAKEN<=result of the selected condition on nf.
- OVF_CNT:
  - Increments by 1 on acc & SCC & V_in.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Cleared only by RESET.
- Latency: exactly 1 cycle from an accepted input to the WB_* / PSR / BR_TAKEN outputs.
- Back-to-back accepts: each cycle's result overwrites the previous one; there is no buffering beyond one entry.
- An instruction presented during STALL is not captured. Upstream must keep it stable until STALL deasserts.

Test Plan:
- Reset:
  - Stimulus: RESET=1 for 2 cycles with EX_VALID=1, F=32'hFFFFFFFF, SCC=1, V_in=1.
  - Required: all outputs 0, OVF_CNT=0. After RESET falls, the next accept gives WB_DATA=FFFFFFFF and PSR=4'b0011 (N_in=1, V_in=1).
- Capture and R0 suppression:
  - F=32'h55555554, DA=5, RW=1, MD=0 -> WB_DATA=55555554, WB_DA=5, WB_RW=1 after 1 cycle.
  - Same stimulus with DA=0 -> WB_RW=0, WB_VALID=1.
- Set-less-than select:
  - MD=1, N_in=1, V_in=0 -> WB_DATA=32'h00000001.
  - MD=1, N_in=1, V_in=1 -> WB_DATA=32'h00000000.
- Flag forwarding to branch:
  - Prior PSR=4'b0000. Accept SCC=1, Z_in=1, BC=001 -> BR_TAKEN=1, PSR=4'b1000.
  - Next cycle SCC=0, BC=010 -> BR_TAKEN=0, since it is evaluated on the held PSR.
- Stall and flush:
  - STALL=1 for 3 cycles while F changes -> all outputs hold their values.
  - FLUSH=1 together with STALL=1 -> WB_VALID=0, WB_RW=0; PSR is unchanged even if SCC=1.
- Counter saturation:
  - CNT_W=2; present 5 accepted SCC=1, V_in=1 instructions -> OVF_CNT sequence 1,2,3,3,3.
  - A V_in=1 instruction with SCC=0 -> no increment.
